// File: rtl/nn_pkg.sv
// Shared types and constants for the NN stream sequencer: parameter-register
// addresses and the sequencer state encoding.
package nn_pkg;

   localparam int DW_DEF   = 2;
   localparam int N_PARAMS = 9;

   localparam logic [3:0] ADDR_W00 = 4'd0;
   localparam logic [3:0] ADDR_W01 = 4'd1;
   localparam logic [3:0] ADDR_W10 = 4'd2;
   localparam logic [3:0] ADDR_W11 = 4'd3;
   localparam logic [3:0] ADDR_W20 = 4'd4;
   localparam logic [3:0] ADDR_W21 = 4'd5;
   localparam logic [3:0] ADDR_U00 = 4'd6;
   localparam logic [3:0] ADDR_U10 = 4'd7;
   localparam logic [3:0] ADDR_U20 = 4'd8;
   localparam logic [3:0] ADDR_MAX = 4'd8;

   typedef enum logic [1:0] {
      ST_CFG   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/nn_result_fifo.sv
// Synchronous result FIFO: registered head, occupancy count, pop ignored when empty.
module nn_result_fifo
   import nn_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push,
   input  logic [DW-1:0]                   push_data,
   input  logic                            pop,
   output logic [DW-1:0]                   head,
   output logic [$clog2(FIFO_DEPTH):0]     count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = mem[rptr];

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nn_stream_sequencer.sv
// Front/back end for the combinational NN core: parameter regfile, CFG/RUN/DRAIN
// control, registered operands and a result FIFO with valid/ready egress.
module nn_stream_sequencer
   import nn_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [DW-1:0] cfg_wdata,
   input  logic          cfg_commit,
   input  logic          cfg_unlock,
   output logic          cfg_err,
   output logic [1:0]    state_o,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_x0,
   input  logic [DW-1:0] in_x1,
   output logic [DW-1:0] x0,
   output logic [DW-1:0] x1,
   output logic [DW-1:0] w00,
   output logic [DW-1:0] w01,
   output logic [DW-1:0] w10,
   output logic [DW-1:0] w11,
   output logic [DW-1:0] w20,
   output logic [DW-1:0] w21,
   output logic [DW-1:0] u00,
   output logic [DW-1:0] u10,
   output logic [DW-1:0] u20,
   input  logic [DW-1:0] net_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t        state_q;
   logic [DW-1:0] prm [N_PARAMS];
   logic          inflight;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          cfg_ok;
   logic          accept;
   logic          pop;

   assign cfg_ok   = (state_q == ST_CFG) && (cfg_addr <= ADDR_MAX);
   // A sample in flight has a FIFO slot reserved, so overflow is impossible.
   assign occ      = {1'b0, count} + (CW+1)'(inflight);
   assign in_ready = (state_q == ST_RUN) && (occ < (CW+1)'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;
   assign res_valid = (count != '0);
   assign pop      = res_valid && res_ready;
   assign state_o  = state_q;

   assign w00 = prm[ADDR_W00];
   assign w01 = prm[ADDR_W01];
   assign w10 = prm[ADDR_W10];
   assign w11 = prm[ADDR_W11];
   assign w20 = prm[ADDR_W20];
   assign w21 = prm[ADDR_W21];
   assign u00 = prm[ADDR_U00];
   assign u10 = prm[ADDR_U10];
   assign u20 = prm[ADDR_U20];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PARAMS; i++) begin
            prm[i] <= '0;
         end
      end else if (cfg_we && cfg_ok) begin
         prm[cfg_addr] <= cfg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CFG;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         case (state_q)
            ST_CFG:   if (cfg_commit) state_q <= ST_RUN;
            ST_RUN:   if (cfg_unlock) state_q <= ST_DRAIN;
            ST_DRAIN: if (!inflight && (count == '0)) state_q <= ST_CFG;
            default:  state_q <= ST_CFG;
         endcase
      end
   end

   // Operand stage: the core settles during the cycle after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0       <= '0;
         x1       <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) begin
            x0 <= in_x0;
            x1 <= in_x1;
         end
      end
   end

   nn_result_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (net_out),
      .pop       (pop),
      .head      (res_data),
      .count     (count)
   );

endmodule

// File: tb/tb_nn_stream_sequencer.sv
// Directed bench for nn_stream_sequencer with a table-based stand-in for the NN core.
module tb_nn_stream_sequencer;

   localparam int DW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we, cfg_commit, cfg_unlock, cfg_err;
   logic [3:0]    cfg_addr;
   logic [DW-1:0] cfg_wdata;
   logic [1:0]    state_o;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_x0, in_x1, x0, x1;
   logic [DW-1:0] w00, w01, w10, w11, w20, w21, u00, u10, u20;
   logic [DW-1:0] net_out;
   logic          res_valid, res_ready;
   logic [DW-1:0] res_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nn_stream_sequencer #(.DW(DW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_commit(cfg_commit), .cfg_unlock(cfg_unlock), .cfg_err(cfg_err),
      .state_o(state_o),
      .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_x1(in_x1),
      .x0(x0), .x1(x1),
      .w00(w00), .w01(w01), .w10(w10), .w11(w11), .w20(w20), .w21(w21),
      .u00(u00), .u10(u10), .u20(u20),
      .net_out(net_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   // Core stand-in: fixed truth table on {x0,x1}, perturbed by w00^u20 (00 once loaded).
   function automatic logic [1:0] core_f(input logic [1:0] a, input logic [1:0] b);
      case ({a, b})
         4'd0:  return 2'b00;  4'd1:  return 2'b10;
         4'd2:  return 2'b01;  4'd3:  return 2'b11;
         4'd4:  return 2'b00;  4'd5:  return 2'b01;
         4'd6:  return 2'b10;  4'd7:  return 2'b11;
         4'd8:  return 2'b01;  4'd9:  return 2'b11;
         4'd10: return 2'b00;  4'd11: return 2'b10;
         4'd12: return 2'b11;  4'd13: return 2'b00;
         4'd14: return 2'b01;  default: return 2'b10;
      endcase
   endfunction

   always_comb net_out = core_f(x0, x1) ^ w00 ^ u20;

   function automatic logic [1:0] prm_of(input int a);
      case (a)
         0: return w00;  1: return w01;  2: return w10;
         3: return w11;  4: return w20;  5: return w21;
         6: return u00;  7: return u10;  default: return u20;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [1:0] x0;
      logic [1:0] x1;
      logic [1:0] res;
   } vec_t;

   vec_t       vt [4];
   logic [3:0] ld_addr [9];
   logic [1:0] ld_data [9];
   logic [1:0] sx0 [6];
   logic [1:0] sx1 [6];
   int         idx;
   int         waited;
   logic       rdy;

   initial begin
      // Addresses 0..8: w00,w01,w10,w11,w20,w21,u00,u10,u20
      ld_addr[0] = 4'd0; ld_data[0] = 2'b11;
      ld_addr[1] = 4'd1; ld_data[1] = 2'b10;
      ld_addr[2] = 4'd2; ld_data[2] = 2'b01;
      ld_addr[3] = 4'd3; ld_data[3] = 2'b01;
      ld_addr[4] = 4'd6; ld_data[4] = 2'b01;
      ld_addr[5] = 4'd4; ld_data[5] = 2'b11;
      ld_addr[6] = 4'd5; ld_data[6] = 2'b11;
      ld_addr[7] = 4'd8; ld_data[7] = 2'b11;
      ld_addr[8] = 4'd7; ld_data[8] = 2'b01;

      vt[0] = '{x0: 2'b00, x1: 2'b00, res: 2'b00};
      vt[1] = '{x0: 2'b00, x1: 2'b10, res: 2'b01};
      vt[2] = '{x0: 2'b00, x1: 2'b11, res: 2'b11};
      vt[3] = '{x0: 2'b01, x1: 2'b00, res: 2'b00};

      sx0[0] = 2'b00; sx1[0] = 2'b01;
      sx0[1] = 2'b01; sx1[1] = 2'b01;
      sx0[2] = 2'b01; sx1[2] = 2'b10;
      sx0[3] = 2'b10; sx1[3] = 2'b00;
      sx0[4] = 2'b11; sx1[4] = 2'b00;
      sx0[5] = 2'b10; sx1[5] = 2'b11;

      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      cfg_commit = 1'b0; cfg_unlock = 1'b0;
      in_valid = 1'b0; in_x0 = '0; in_x1 = '0; res_ready = 1'b0;

      #12;
      chk("rst_state", state_o, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_x0", x0, 0);
      chk("rst_w00", w00, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Parameter load and commit
      for (int i = 0; i < 9; i++) begin
         cfg_we = 1'b1; cfg_addr = ld_addr[i]; cfg_wdata = ld_data[i];
         step();
         chk("load_err", cfg_err, 0);
      end
      cfg_we = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("param%0d", ld_addr[i]), prm_of(int'(ld_addr[i])), ld_data[i]);
      end
      chk("cfg_in_ready", in_ready, 0);
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      chk("commit_state", state_o, 1);
      chk("run_in_ready", in_ready, 1);

      // Table-driven stream, consumer stalled so all four results buffer
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_x0 = vt[i].x0; in_x1 = vt[i].x1;
         chk($sformatf("tbl_rdy%0d", i), in_ready, 1);
         step();
         chk($sformatf("tbl_x0_%0d", i), x0, vt[i].x0);
         chk($sformatf("tbl_x1_%0d", i), x1, vt[i].x1);
      end
      in_valid = 1'b0;
      step();
      chk("tbl_full_rdy", in_ready, 0);
      chk("tbl_x0_hold", x0, vt[3].x0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("tbl_vld%0d", i), res_valid, 1);
         chk($sformatf("tbl_res%0d", i), res_data, vt[i].res);
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
      end
      chk("tbl_empty", res_valid, 0);

      // Latency: accept at edge N, res_valid first high after edge N+1
      in_valid = 1'b1; in_x0 = 2'b11; in_x1 = 2'b01;
      chk("lat_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("lat_n1_vld", res_valid, 0);
      step();
      chk("lat_n2_vld", res_valid, 1);
      chk("lat_res", res_data, core_f(2'b11, 2'b01));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("lat_empty", res_valid, 0);

      // Backpressure: six offered, only four fit
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         if (idx < 6) begin
            in_valid = 1'b1; in_x0 = sx0[idx]; in_x1 = sx1[idx];
         end else begin
            in_valid = 1'b0;
         end
         rdy = in_ready;
         step();
         if (rdy && idx < 6) idx++;
      end
      in_valid = 1'b0;
      chk("bp_accepted", idx, 4);
      chk("bp_in_ready", in_ready, 0);
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp_vld%0d", k), res_valid, 1);
         chk($sformatf("bp_res%0d", k), res_data, core_f(sx0[k], sx1[k]));
         step();
      end
      res_ready = 1'b0;
      waited = 0;
      while (idx < 6 && waited < 10) begin
         in_valid = 1'b1; in_x0 = sx0[idx]; in_x1 = sx1[idx];
         rdy = in_ready;
         step();
         if (rdy) idx++;
         waited++;
      end
      in_valid = 1'b0;
      chk("bp_rest_accepted", idx, 6);
      step();
      res_ready = 1'b1;
      for (int k = 4; k < 6; k++) begin
         chk($sformatf("bp_vld%0d", k), res_valid, 1);
         chk($sformatf("bp_res%0d", k), res_data, core_f(sx0[k], sx1[k]));
         step();
      end
      res_ready = 1'b0;
      chk("bp_no_dup", res_valid, 0);

      // Config write while running is rejected
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 2'b00;
      step();
      cfg_we = 1'b0;
      chk("run_wr_err", cfg_err, 1);
      chk("run_wr_w00", w00, 2'b11);
      step();
      chk("run_err_pulse", cfg_err, 0);

      // Unlock with one in flight and two buffered
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_x0 = vt[i].x0; in_x1 = vt[i].x1;
         step();
      end
      in_valid = 1'b0;
      cfg_unlock = 1'b1;
      step();
      cfg_unlock = 1'b0;
      chk("drain_state", state_o, 2);
      chk("drain_in_ready", in_ready, 0);
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain_vld%0d", i), res_valid, 1);
         chk($sformatf("drain_res%0d", i), res_data, vt[i].res);
         step();
      end
      res_ready = 1'b0;
      waited = 0;
      while (state_o != 2'd0 && waited < 4) begin
         step();
         waited++;
      end
      chk("drain_to_cfg", state_o, 0);

      // Unmapped address in CFG, then write and commit together
      cfg_we = 1'b1; cfg_addr = 4'd12; cfg_wdata = 2'b01;
      step();
      cfg_we = 1'b0;
      chk("unmapped_err", cfg_err, 1);
      cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 2'b01; cfg_commit = 1'b1;
      step();
      cfg_we = 1'b0; cfg_commit = 1'b0;
      chk("wc_err", cfg_err, 0);
      chk("wc_w01", w01, 2'b01);
      chk("wc_state", state_o, 1);

      // Asynchronous reset with three results buffered
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_x0 = sx0[i]; in_x1 = sx1[i];
         step();
      end
      in_valid = 1'b0;
      step();
      chk("pre_rst_vld", res_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", res_valid, 0);
      chk("mid_rst_state", state_o, 0);
      chk("mid_rst_w00", w00, 0);
      chk("mid_rst_u20", u20, 0);
      chk("mid_rst_x0", x0, 0);
      chk("mid_rst_rdy", in_ready, 0);
      #2;
      rst_n = 1'b1;
      step();
      chk("post_rst_vld", res_valid, 0);
      chk("post_rst_state", state_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
